// File: rtl/xgmm_pkg.sv
// Shared types and address helpers for the XGMM FIFO drain path.
// Optional build macro: XGMM_ATTR_PRIORITY_EN (attribute-first arbitration).
package xgmm_pkg;

  localparam int PAR_W   = 12;
  localparam int AAR_W   = 13;
  localparam int VADDR_W = 15;
  localparam int DATA_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    REQ
  } drain_state_t;

  typedef enum logic {
    SRC_P,
    SRC_A
  } src_t;

  // Pattern lines are 4 words; p_cnt picks the word within the line.
  function automatic logic [VADDR_W-1:0] pat_addr(
    input logic [VADDR_W-1:0] base,
    input logic [PAR_W-1:0]   par,
    input logic [1:0]         cnt
  );
    return base | {1'b0, par, cnt};
  endfunction

  function automatic logic [VADDR_W-1:0] attr_addr(
    input logic [VADDR_W-1:0] base,
    input logic [AAR_W-1:0]   aar
  );
    return base | {2'b00, aar};
  endfunction

endpackage

// File: rtl/xgmm_rr_arb2.sv
// Two-way pattern/attribute source select for the FIFO drain.
// XGMM_ATTR_PRIORITY_EN turns round-robin into attribute-first.
module xgmm_rr_arb2
  import xgmm_pkg::*;
(
  input  logic p_req,
  input  logic a_req,
  input  src_t last_src,
  output logic gnt_valid,
  output src_t gnt_src
);

  assign gnt_valid = p_req | a_req;

`ifdef XGMM_ATTR_PRIORITY_EN
  logic unused_last;
  assign unused_last = last_src;

  always_comb begin
    gnt_src = SRC_P;
    if (a_req)
      gnt_src = SRC_A;
  end
`else
  always_comb begin
    gnt_src = SRC_P;
    unique case (1'b1)
      p_req & a_req:
        gnt_src = (last_src == SRC_P) ? SRC_A : SRC_P;
      a_req & ~p_req:
        gnt_src = SRC_A;
      default:
        gnt_src = SRC_P;
    endcase
  end
`endif

endmodule

// File: rtl/xgmm_fifo_drain.sv
// Drains pattern/attribute FIFOs into VRAM via a req/gnt write port.
// Build macro XGMM_ATTR_PRIORITY_EN selects attribute-first arbitration.
module xgmm_fifo_drain
  import xgmm_pkg::*;
#(
  parameter logic [VADDR_W-1:0] P_BASE = 15'h0000,
  parameter logic [VADDR_W-1:0] A_BASE = 15'h4000
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               drain_en,
  input  logic               p_empty,
  input  logic               a_empty,
  input  logic [DATA_W-1:0]  p_data,
  input  logic [DATA_W-1:0]  a_data,
  input  logic [PAR_W-1:0]   par,
  input  logic [AAR_W-1:0]   aar,
  output logic               p_pop,
  output logic               a_pop,
  output logic               mem_req,
  input  logic               mem_gnt,
  output logic [VADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               busy
);

  drain_state_t state_q;
  drain_state_t state_d;
  src_t         sel_q;
  src_t         last_src_q;
  src_t         arb_src;
  logic         arb_valid;
  logic [1:0]   p_cnt_q;
  logic         p_pop_q;

  xgmm_rr_arb2 u_arb (
    .p_req     (~p_empty),
    .a_req     (~a_empty),
    .last_src  (last_src_q),
    .gnt_valid (arb_valid),
    .gnt_src   (arb_src)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (drain_en && arb_valid)
          state_d = POP;
      POP:
        state_d = REQ;
      REQ:
        if (mem_gnt)
          state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    p_pop   = (state_q == POP) && (sel_q == SRC_P);
    a_pop   = (state_q == POP) && (sel_q == SRC_A);
    mem_req = (state_q == REQ);
    busy    = (state_q != IDLE);
  end

  // p_cnt tracks the interface's burst counter: it advances as the pop
  // pulse falls and any empty FIFO restarts the line.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      p_pop_q <= 1'b0;
      p_cnt_q <= 2'd0;
    end else begin
      p_pop_q <= p_pop;
      if (p_empty)
        p_cnt_q <= 2'd0;
      else if (p_pop_q && !p_pop)
        p_cnt_q <= p_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= SRC_P;
      last_src_q <= SRC_A;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if (state_q == IDLE && state_d == POP)
        sel_q <= arb_src;
      if (state_q == POP) begin
        last_src_q <= sel_q;
        if (sel_q == SRC_P) begin
          mem_addr  <= pat_addr(P_BASE, par, p_cnt_q);
          mem_wdata <= p_data;
        end else begin
          mem_addr  <= attr_addr(A_BASE, aar);
          mem_wdata <= a_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_xgmm_fifo_drain.sv
// Directed bench for xgmm_fifo_drain with FIFO and pointer harness.
// Write log is compared against a hand-computed vector table.
module tb_xgmm_fifo_drain;
  import xgmm_pkg::*;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        drain_en;
  logic        p_empty;
  logic        a_empty;
  logic [15:0] p_data;
  logic [15:0] a_data;
  logic [11:0] par = '0;
  logic [12:0] aar = '0;
  logic        p_pop;
  logic        a_pop;
  logic        mem_req;
  logic        mem_gnt;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;

  xgmm_fifo_drain dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .drain_en  (drain_en),
    .p_empty   (p_empty),
    .a_empty   (a_empty),
    .p_data    (p_data),
    .a_data    (a_data),
    .par       (par),
    .aar       (aar),
    .p_pop     (p_pop),
    .a_pop     (a_pop),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  logic [15:0] pmem [16];
  logic [15:0] amem [16];
  int          pwr = 0;
  int          awr = 0;
  int          prd = 0;
  int          ard = 0;
  logic        force_pe = 1'b0;

  assign p_empty = (prd == pwr) || force_pe;
  assign a_empty = (ard == awr);
  assign p_data  = pmem[prd[3:0]];
  assign a_data  = amem[ard[3:0]];

  logic        pp_s = 1'b0;
  logic        ap_s = 1'b0;
  int          npop = 0;
  logic [14:0] log_addr [32];
  logic [15:0] log_data [32];
  int          nlog = 0;

  always @(negedge clk_sys) begin
    pp_s = p_pop;
    ap_s = a_pop;
    if (p_pop || a_pop)
      npop++;
    if (rst_n && mem_req && mem_gnt && nlog < 32) begin
      log_addr[nlog] = mem_addr;
      log_data[nlog] = mem_wdata;
      nlog++;
    end
  end

  logic        par_ld = 1'b0;
  logic [11:0] par_ld_val = '0;
  logic        aar_ld = 1'b0;
  logic [12:0] aar_ld_val = '0;
  logic [1:0]  hc = '0;
  logic        par_pend = 1'b0;

  // Register-interface stand-in: par moves after each 4th pattern pop,
  // aar steps by 4 per attribute pop.
  always @(posedge clk_sys) begin
    if (pp_s) prd <= prd + 1;
    if (ap_s) ard <= ard + 1;
    par_pend <= pp_s && (hc == 2'd3) && !p_empty;
    if (p_empty)
      hc <= 2'd0;
    else if (pp_s)
      hc <= hc + 2'd1;
    if (par_ld)
      par <= par_ld_val;
    else if (par_pend)
      par <= par + 12'd1;
    if (aar_ld)
      aar <= aar_ld_val;
    else if (ap_s)
      aar <= aar + 13'd4;
  end

  typedef struct {
    string       name;
    logic [14:0] addr;
    logic [15:0] data;
  } wr_vec_t;

  wr_vec_t vec [20];
  int      nvec;
  int      checks = 0;
  int      errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic load_par(input logic [11:0] v);
    tick();
    par_ld_val = v;
    par_ld = 1'b1;
    tick();
    par_ld = 1'b0;
  endtask

  task automatic load_aar(input logic [12:0] v);
    tick();
    aar_ld_val = v;
    aar_ld = 1'b1;
    tick();
    aar_ld = 1'b0;
  endtask

  task automatic push_p(input logic [15:0] d);
    pmem[pwr[3:0]] = d;
    pwr++;
  endtask

  task automatic push_a(input logic [15:0] d);
    amem[awr[3:0]] = d;
    awr++;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    @(negedge clk_sys);
    while (!mem_req && n < 40) begin
      @(negedge clk_sys);
      n++;
    end
    chk(nm, mem_req, 1);
  endtask

  task automatic wait_drained(input string nm);
    int n = 0;
    @(negedge clk_sys);
    while ((busy || !p_empty || !a_empty) && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    chk(nm, {busy, !p_empty, !a_empty}, 0);
  endtask

  int np0;

  initial begin
    vec[0]  = '{"pat0", 15'h048C, 16'hA000};
    vec[1]  = '{"pat1", 15'h048D, 16'hA001};
    vec[2]  = '{"pat2", 15'h048E, 16'hA002};
    vec[3]  = '{"pat3", 15'h048F, 16'hA003};
    vec[4]  = '{"pat4", 15'h0490, 16'hA004};
    vec[5]  = '{"att0", 15'h4010, 16'hB000};
    vec[6]  = '{"att1", 15'h4014, 16'hB001};
    vec[7]  = '{"att2", 15'h4018, 16'hB002};
`ifdef XGMM_ATTR_PRIORITY_EN
    vec[8]  = '{"arb0", 15'h4100, 16'hD000};
    vec[9]  = '{"arb1", 15'h4104, 16'hD001};
    vec[10] = '{"arb2", 15'h0100, 16'hC000};
    vec[11] = '{"arb3", 15'h0101, 16'hC001};
`else
    vec[8]  = '{"arb0", 15'h0100, 16'hC000};
    vec[9]  = '{"arb1", 15'h4100, 16'hD000};
    vec[10] = '{"arb2", 15'h0101, 16'hC001};
    vec[11] = '{"arb3", 15'h4104, 16'hD001};
`endif
    vec[12] = '{"stl0", 15'h0800, 16'hE000};
    vec[13] = '{"stl1", 15'h0801, 16'hE001};
    vec[14] = '{"den0", 15'h0C00, 16'hF000};
    vec[15] = '{"den1", 15'h0C01, 16'hF001};
    vec[16] = '{"den2", 15'h0C00, 16'hF002};
    nvec = 17;

    rst_n    = 1'b0;
    drain_en = 1'b0;
    mem_gnt  = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ppop", p_pop, 0);
    chk("rst_apop", a_pop, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    tick();
    rst_n = 1'b1;

    load_par(12'h123);
    for (int i = 0; i < 4; i++)
      push_p(16'hA000 + 16'(i));
    tick();
    drain_en = 1'b1;
    wait_drained("pat_drain");
    push_p(16'hA004);
    wait_drained("pat_next");

    load_aar(13'h0010);
    for (int i = 0; i < 3; i++)
      push_a(16'hB000 + 16'(i));
    wait_drained("att_drain");

    tick();
    drain_en = 1'b0;
    load_par(12'h040);
    load_aar(13'h0100);
    push_p(16'hC000);
    push_p(16'hC001);
    push_a(16'hD000);
    push_a(16'hD001);
    tick();
    drain_en = 1'b1;
    wait_drained("arb_drain");

    tick();
    mem_gnt = 1'b0;
    load_par(12'h200);
    push_p(16'hE000);
    push_p(16'hE001);
    wait_req("stall_req");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk_sys);
      chk($sformatf("stall_req%0d", i), mem_req, 1);
      chk($sformatf("stall_addr%0d", i), mem_addr, 15'h0800);
      chk($sformatf("stall_wdata%0d", i), mem_wdata, 16'hE000);
      chk($sformatf("stall_pop%0d", i), p_pop, 0);
    end
    tick();
    mem_gnt = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("gnt_idle_busy", busy, 0);
    chk("gnt_idle_pop", p_pop, 0);
    @(negedge clk_sys);
    chk("gnt_next_pop", p_pop, 1);
    wait_drained("stall_drain");

    tick();
    mem_gnt  = 1'b0;
    drain_en = 1'b0;
    load_par(12'h300);
    push_p(16'hF000);
    push_p(16'hF001);
    push_p(16'hF002);
    tick();
    drain_en = 1'b1;
    wait_req("den_req0");
    tick();
    drain_en = 1'b0;
    mem_gnt  = 1'b1;
    np0 = npop;
    repeat (10) @(negedge clk_sys);
    chk("den_nopop", npop - np0, 0);
    chk("den_idle", busy, 0);
    tick();
    mem_gnt  = 1'b0;
    drain_en = 1'b1;
    wait_req("den_req1");
    chk("den_resume_addr", mem_addr, 15'h0C01);
    tick();
    drain_en = 1'b0;
    mem_gnt  = 1'b1;
    repeat (4) @(negedge clk_sys);
    tick();
    force_pe = 1'b1;
    tick();
    force_pe = 1'b0;
    drain_en = 1'b1;
    wait_drained("den_drain");

    tick();
    mem_gnt = 1'b0;
    push_p(16'h1234);
    wait_req("arst_req");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_pop", p_pop, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", mem_addr, 0);
    drain_en = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("arst_idle", busy, 0);
    chk("arst_idle_req", mem_req, 0);

    chk("nwrites", nlog, nvec);
    for (int i = 0; i < nvec; i++) begin
      chk($sformatf("%s_addr", vec[i].name), log_addr[i], vec[i].addr);
      chk($sformatf("%s_data", vec[i].name), log_data[i], vec[i].data);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xgmm_fifo_drain.md
Name: xgmm_fifo_drain

Overview:
- XGMM-side consumer of the pattern FIFO and attribute FIFO loaded by the CPU register interface.
- Pops one word at a time, forms the video-memory word address from the interface's par/aar pointers plus a local burst index, and writes the word through a request/grant port into the shared VRAM arbiter.
- Sits between the register interface and the VRAM arbiter. Its pop timing is what advances par/aar.

Parameters:
- P_BASE, 15'h0000, VRAM word base OR'd into pattern addresses.
- A_BASE, 15'h4000, VRAM word base OR'd into attribute addresses.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- drain_en  in  1  1 = allowed to start new transfers. 0 = finish any in-flight write, then idle.
- p_empty  in  1  pattern FIFO empty.
- a_empty  in  1  attribute FIFO empty.
- p_data  in  16  pattern FIFO head (show-ahead).
- a_data  in  16  attribute FIFO head (show-ahead).
- par  in  12  pattern line pointer, 4 words per line.
- aar  in  13  attribute word pointer.
- p_pop  out  1  pattern pop, single-cycle pulse.
- a_pop  out  1  attribute pop, single-cycle pulse.
- mem_req  out  1  write request.
- mem_gnt  in  1  write accepted in any cycle where mem_req & mem_gnt.
- mem_addr  out  15  VRAM word address.
- mem_wdata  out  16  write data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low, async): state=IDLE; p_pop, a_pop, mem_req, busy = 0; mem_addr, mem_wdata = 0; p_cnt = 0; last_src = attribute, so pattern wins the first tie.
- p_cnt[1:0] mirrors the interface burst counter:
  - cleared in any cycle where p_empty = 1;
  - otherwise incremented in the cycle after a p_pop pulse (falling edge of p_pop);
  - wraps 3 -> 0.
- FSM states: IDLE, POP, REQ.
- IDLE:
  - If drain_en and at least one FIFO is non-empty, select a source and go to POP.
  - Both non-empty: round-robin, the source not served last wins.
- POP (exactly 1 cycle):
  - Assert the selected pop.
  - Capture the head word into mem_wdata.
  - Capture mem_addr:
    - pattern: P_BASE | {1'b0, par, p_cnt}
    - attribute: A_BASE | {2'b00, aar}
  - Record last_src. Go to REQ.
- REQ:
  - Hold mem_req = 1 with mem_addr and mem_wdata stable until mem_gnt = 1.
  - Deassert mem_req in the cycle after the grant. Return to IDLE.
- Minimum pop spacing is 3 cycles (POP, REQ, IDLE). This guarantees par/aar/p_cnt have updated (they update one cycle after the pop's falling edge) before the next capture.
- drain_en dropping during POP or REQ does not abort; the write completes. No new POP starts while drain_en = 0.
- Empty change between IDLE decision and POP cannot occur: only this block pops.
- p_empty rising mid-line clears p_cnt. The next pattern word then lands at {par, 2'b00}, matching the interface.
- Address arithmetic is a pure OR with the base; no carry. Bases must be aligned to the region size.
- Throughput with mem_gnt tied high: one word per 3 cycles.

Optional Feature:
- Macro XGMM_ATTR_PRIORITY_EN.
- Defined: attribute FIFO has strict priority in IDLE; pattern is served only when a_empty = 1. last_src is unused.
- Undefined: round-robin as above.

Decomposition:
- Package xgmm_pkg holds:
  - state enum drain_state_t {IDLE, POP, REQ};
  - source enum src_t {SRC_P, SRC_A};
  - widths: PAR_W = 12, AAR_W = 13, VADDR_W = 15.
- One natural sub-module, xgmm_rr_arb2: 2-way round-robin select with the priority override.

Test Plan:
- Reset: hold rst_n = 0 mid-REQ with mem_req = 1 -> mem_req, p_pop, busy = 0 immediately (async). After release, FSM is in IDLE.
- Pattern burst: par = 12'h123, 4 pattern words 16'hA000..A003, mem_gnt = 1, harness advances par after 4th pop -> writes to 15'h048C, 048D, 048E, 048F; next word goes to 15'h0490.
- Attribute: aar = 13'h0010, harness steps aar by 4 per pop, 3 words -> writes to 15'h4010, 4014, 4018, each with matching data.
- Arbitration: both FIFOs hold 2 words -> write order P, A, P, A. With XGMM_ATTR_PRIORITY_EN -> A, A, P, P.
- Grant stall: mem_gnt = 0 for 5 cycles -> mem_req, mem_addr, mem_wdata stable; no further pop until 1 cycle after the grant.
- drain_en = 0 asserted during REQ -> current write completes, then no pops while FIFOs non-empty. Re-enable -> resumes with correct p_cnt. Forcing p_empty = 1 for one cycle mid-line -> next pattern address low bits = 2'b00.
